// File: rtl/vga_async_fifo_wm.sv
// Dual-clock FIFO with gray-coded pointer crossing, watermarks, FWFT/registered read port and
// flush handshake. Optional sticky error flags are enabled by VGA_ASYNC_FIFO_ERRFLAG_EN.
module vga_async_fifo_wm #(
    parameter int unsigned N           = 16,
    parameter int unsigned D_N         = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AFULL_TH    = 3,
    parameter int unsigned AEMPTY_TH   = 1,
    parameter int unsigned RD_MODE     = 0
) (
    input  logic           inRESET,
    input  logic           iWR_CLOCK,
    input  logic           iRD_CLOCK,
    input  logic           iWR_EN,
    input  logic [N-1:0]   iWR_DATA,
    input  logic           iWR_FLUSH,
    output logic           oWR_FULL,
    output logic           oWR_AFULL,
    output logic [D_N:0]   oWR_COUNT,
    output logic           oWR_FLUSH_BUSY,
    output logic           oWR_OVERFLOW,
    input  logic           iRD_EN,
    output logic [N-1:0]   oRD_DATA,
    output logic           oRD_VALID,
    output logic           oRD_EMPTY,
    output logic           oRD_AEMPTY,
    output logic [D_N:0]   oRD_COUNT,
    output logic           oRD_UNDERFLOW
);

    localparam int unsigned DEPTH = 2 ** D_N;
    localparam logic [D_N:0] DEPTH_CNT = {1'b1, {D_N{1'b0}}};
    localparam logic [D_N:0] PTR_ONE   = {{D_N{1'b0}}, 1'b1};

    function automatic logic [D_N:0] bin2gray(input logic [D_N:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [D_N:0] gray2bin(input logic [D_N:0] g);
        logic [D_N:0] b;
        b[D_N] = g[D_N];
        for (int i = int'(D_N) - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [N-1:0] mem_q [DEPTH];

    // Write domain
    logic [D_N:0]                  wr_ptr_q, wr_ptr_d, wr_gray_q;
    logic [SYNC_STAGES-1:0][D_N:0] rd_gray_sync_q;
    logic [SYNC_STAGES-1:0]        ack_sync_q;
    logic [D_N:0]                  rd_sync, wr_count;
    logic                          busy_q, busy_d, req_q, req_d;
    logic                          wr_full_raw, wr_accept, flush_start;

    // Read domain
    logic [D_N:0]                  rd_ptr_q, rd_ptr_d, rd_gray_q;
    logic [SYNC_STAGES-1:0][D_N:0] wr_gray_sync_q;
    logic [SYNC_STAGES-1:0]        req_sync_q;
    logic [D_N:0]                  wr_sync, rd_count;
    logic                          req_seen_q, ack_q;
    logic                          rd_empty, rd_flush, rd_pop;
    logic [N-1:0]                  rd_head;

    always_comb begin
        rd_sync     = gray2bin(rd_gray_sync_q[SYNC_STAGES-1]);
        wr_count    = wr_ptr_q - rd_sync;
        wr_full_raw = (wr_count == DEPTH_CNT);
        flush_start = iWR_FLUSH & ~busy_q;
        // A write coinciding with a flush request is dropped.
        wr_accept   = iWR_EN & ~wr_full_raw & ~busy_q & ~iWR_FLUSH;
        wr_ptr_d    = wr_accept ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        busy_d      = busy_q;
        req_d       = req_q;
        if (flush_start) begin
            busy_d = 1'b1;
            req_d  = ~req_q;
        end else if (busy_q && (ack_sync_q[SYNC_STAGES-1] == req_q)) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge iWR_CLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wr_ptr_q       <= '0;
            wr_gray_q      <= '0;
            rd_gray_sync_q <= '0;
            ack_sync_q     <= '0;
            busy_q         <= 1'b0;
            req_q          <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            wr_gray_q      <= bin2gray(wr_ptr_d);
            rd_gray_sync_q <= {rd_gray_sync_q[SYNC_STAGES-2:0], rd_gray_q};
            ack_sync_q     <= {ack_sync_q[SYNC_STAGES-2:0], ack_q};
            busy_q         <= busy_d;
            req_q          <= req_d;
        end
    end

    always_ff @(posedge iWR_CLOCK) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q[D_N-1:0]] <= iWR_DATA;
        end
    end

    assign oWR_FULL       = wr_full_raw | busy_q;
    assign oWR_AFULL      = (32'(wr_count) >= AFULL_TH);
    assign oWR_COUNT      = wr_count;
    assign oWR_FLUSH_BUSY = busy_q;

    always_comb begin
        wr_sync  = gray2bin(wr_gray_sync_q[SYNC_STAGES-1]);
        rd_count = wr_sync - rd_ptr_q;
        rd_empty = (rd_count == '0);
        rd_flush = req_sync_q[SYNC_STAGES-1] ^ req_seen_q;
        rd_pop   = iRD_EN & ~rd_empty & ~rd_flush;
        rd_head  = mem_q[rd_ptr_q[D_N-1:0]];
        if (rd_flush) begin
            rd_ptr_d = wr_sync;
        end else if (rd_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // ack trails the flush action by one edge so the jumped rd gray has settled before ack leaves.
    always_ff @(posedge iRD_CLOCK or negedge inRESET) begin
        if (!inRESET) begin
            rd_ptr_q       <= '0;
            rd_gray_q      <= '0;
            wr_gray_sync_q <= '0;
            req_sync_q     <= '0;
            req_seen_q     <= 1'b0;
            ack_q          <= 1'b0;
        end else begin
            rd_ptr_q       <= rd_ptr_d;
            rd_gray_q      <= bin2gray(rd_ptr_d);
            wr_gray_sync_q <= {wr_gray_sync_q[SYNC_STAGES-2:0], wr_gray_q};
            req_sync_q     <= {req_sync_q[SYNC_STAGES-2:0], req_q};
            req_seen_q     <= req_sync_q[SYNC_STAGES-1];
            ack_q          <= req_seen_q;
        end
    end

    assign oRD_EMPTY  = rd_empty;
    assign oRD_AEMPTY = (32'(rd_count) <= AEMPTY_TH);
    assign oRD_COUNT  = rd_count;

    if (RD_MODE == 0) begin : g_fwft
        assign oRD_DATA  = rd_head;
        assign oRD_VALID = ~rd_empty;
    end else begin : g_reg
        logic [N-1:0] rd_data_q;
        logic         rd_valid_q;

        always_ff @(posedge iRD_CLOCK or negedge inRESET) begin
            if (!inRESET) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_pop;
                if (rd_pop) begin
                    rd_data_q <= rd_head;
                end
            end
        end

        assign oRD_DATA  = rd_data_q;
        assign oRD_VALID = rd_valid_q;
    end

`ifdef VGA_ASYNC_FIFO_ERRFLAG_EN
    logic overflow_q, overflow_d, underflow_q, underflow_d;

    always_comb begin
        overflow_d = overflow_q;
        if (flush_start) begin
            overflow_d = 1'b0;
        end else if (iWR_EN && wr_full_raw && !busy_q) begin
            overflow_d = 1'b1;
        end
        underflow_d = underflow_q;
        if (rd_flush) begin
            underflow_d = 1'b0;
        end else if (iRD_EN && rd_empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge iWR_CLOCK or negedge inRESET) begin
        if (!inRESET) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge iRD_CLOCK or negedge inRESET) begin
        if (!inRESET) begin
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
        end
    end

    assign oWR_OVERFLOW  = overflow_q;
    assign oRD_UNDERFLOW = underflow_q;
`else
    assign oWR_OVERFLOW  = 1'b0;
    assign oRD_UNDERFLOW = 1'b0;
`endif

endmodule

// File: tb/tb_vga_async_fifo_wm.sv
// Directed bench for vga_async_fifo_wm: FWFT instance for most scenarios, registered-read
// instance for the RD_MODE=1 port.
module tb_vga_async_fifo_wm;

`ifdef VGA_ASYNC_FIFO_ERRFLAG_EN
    localparam logic ERRF = 1'b1;
`else
    localparam logic ERRF = 1'b0;
`endif

    localparam logic [13:0] RST_STATUS = {1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0,
                                          1'b0, 1'b0};

    int tests = 0;
    int fails = 0;
    int rd_half = 6;

    logic wr_clk, rd_clk, rst_n;
    logic wr_en, wr_flush, rd_en;
    logic [15:0] wr_data;
    logic wr_full, wr_afull, wr_busy, wr_ovf, rd_valid, rd_empty, rd_aempty, rd_unf;
    logic [2:0] wr_count, rd_count;
    logic [15:0] rd_data;

    logic wr_en1, rd_en1;
    logic [15:0] wr_data1;
    logic wr_full1, wr_afull1, wr_busy1, wr_ovf1, rd_valid1, rd_empty1, rd_aempty1, rd_unf1;
    logic [2:0] wr_count1, rd_count1;
    logic [15:0] rd_data1;
    logic flush1;

    vga_async_fifo_wm #(.RD_MODE(0)) dut (
        .inRESET(rst_n), .iWR_CLOCK(wr_clk), .iRD_CLOCK(rd_clk),
        .iWR_EN(wr_en), .iWR_DATA(wr_data), .iWR_FLUSH(wr_flush),
        .oWR_FULL(wr_full), .oWR_AFULL(wr_afull), .oWR_COUNT(wr_count),
        .oWR_FLUSH_BUSY(wr_busy), .oWR_OVERFLOW(wr_ovf),
        .iRD_EN(rd_en), .oRD_DATA(rd_data), .oRD_VALID(rd_valid), .oRD_EMPTY(rd_empty),
        .oRD_AEMPTY(rd_aempty), .oRD_COUNT(rd_count), .oRD_UNDERFLOW(rd_unf)
    );

    vga_async_fifo_wm #(.RD_MODE(1)) dut1 (
        .inRESET(rst_n), .iWR_CLOCK(wr_clk), .iRD_CLOCK(rd_clk),
        .iWR_EN(wr_en1), .iWR_DATA(wr_data1), .iWR_FLUSH(flush1),
        .oWR_FULL(wr_full1), .oWR_AFULL(wr_afull1), .oWR_COUNT(wr_count1),
        .oWR_FLUSH_BUSY(wr_busy1), .oWR_OVERFLOW(wr_ovf1),
        .iRD_EN(rd_en1), .oRD_DATA(rd_data1), .oRD_VALID(rd_valid1), .oRD_EMPTY(rd_empty1),
        .oRD_AEMPTY(rd_aempty1), .oRD_COUNT(rd_count1), .oRD_UNDERFLOW(rd_unf1)
    );

    initial begin
        wr_clk = 1'b0;
        forever #6 wr_clk = ~wr_clk;
    end

    initial begin
        rd_clk = 1'b0;
        #3;
        forever begin
            #(rd_half);
            rd_clk = ~rd_clk;
        end
    end

    function automatic logic [13:0] status0();
        return {wr_full, wr_afull, wr_count, wr_busy, wr_ovf, rd_empty, rd_aempty, rd_count,
                rd_valid, rd_unf};
    endfunction

    task automatic wr_word(input logic [15:0] d);
        @(negedge wr_clk);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge wr_clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_rd_count(input logic [2:0] n, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge rd_clk);
            if (rd_count == n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pop_word(output logic [15:0] d);
        @(negedge rd_clk);
        d     = rd_data;
        rd_en = 1'b1;
        @(negedge rd_clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge wr_clk);
        tests++;
        if (status0() !== RST_STATUS) begin
            fails++;
            $display("FAIL reset_status got=%b exp=%b", status0(), RST_STATUS);
        end
        tests++;
        if ({rd_valid1, rd_data1} !== 17'd0) begin
            fails++;
            $display("FAIL reset_rdmode1 got valid=%b data=%h exp valid=0 data=0000",
                     rd_valid1, rd_data1);
        end
    endtask

    task automatic test_fill();
        logic [15:0] exp_w [4];
        logic [15:0] d;
        logic ok;
        exp_w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        wr_word(exp_w[0]);
        wr_word(exp_w[1]);
        tests++;
        if ({wr_afull, wr_count} !== {1'b0, 3'd2}) begin
            fails++;
            $display("FAIL fill2_afull got afull=%b cnt=%0d exp afull=0 cnt=2", wr_afull, wr_count);
        end
        wr_word(exp_w[2]);
        tests++;
        if ({wr_full, wr_afull} !== 2'b01) begin
            fails++;
            $display("FAIL fill3_flags got full=%b afull=%b exp full=0 afull=1", wr_full, wr_afull);
        end
        wr_word(exp_w[3]);
        tests++;
        if ({wr_full, wr_count} !== {1'b1, 3'd4}) begin
            fails++;
            $display("FAIL fill4_full got full=%b cnt=%0d exp full=1 cnt=4", wr_full, wr_count);
        end
        wr_word(16'h5555);
        tests++;
        if ({wr_ovf, wr_count} !== {ERRF, 3'd4}) begin
            fails++;
            $display("FAIL overflow got ovf=%b cnt=%0d exp ovf=%b cnt=4", wr_ovf, wr_count, ERRF);
        end
        wait_rd_count(3'd4, ok);
        tests++;
        if (ok !== 1'b1) begin
            fails++;
            $display("FAIL fill_visible got rd_count=%0d exp 4", rd_count);
        end
        for (int i = 0; i < 4; i++) begin
            pop_word(d);
            tests++;
            if (d !== exp_w[i]) begin
                fails++;
                $display("FAIL pop_order[%0d] got=%h exp=%h", i, d, exp_w[i]);
            end
            if (i == 1) begin
                tests++;
                if (rd_aempty !== 1'b0) begin
                    fails++;
                    $display("FAIL aempty_at2 got=%b exp=0", rd_aempty);
                end
            end
            if (i == 2) begin
                tests++;
                if (rd_aempty !== 1'b1) begin
                    fails++;
                    $display("FAIL aempty_at1 got=%b exp=1", rd_aempty);
                end
            end
        end
        tests++;
        if ({rd_empty, rd_count} !== {1'b1, 3'd0}) begin
            fails++;
            $display("FAIL drained got empty=%b cnt=%0d exp empty=1 cnt=0", rd_empty, rd_count);
        end
        rd_en = 1'b1;
        @(negedge rd_clk);
        rd_en = 1'b0;
        tests++;
        if ({rd_unf, rd_empty} !== {ERRF, 1'b1}) begin
            fails++;
            $display("FAIL underflow got unf=%b empty=%b exp unf=%b empty=1", rd_unf, rd_empty,
                     ERRF);
        end
    endtask

    task automatic test_rd_mode1();
        logic ok;
        @(negedge wr_clk);
        wr_en1   = 1'b1;
        wr_data1 = 16'h5A5A;
        @(negedge wr_clk);
        wr_data1 = 16'h6B6B;
        @(negedge wr_clk);
        wr_en1   = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge rd_clk);
            if (rd_count1 == 3'd2) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if ({ok, rd_valid1} !== 2'b10) begin
            fails++;
            $display("FAIL rm1_ready got ok=%b valid=%b exp ok=1 valid=0", ok, rd_valid1);
        end
        rd_en1 = 1'b1;
        @(negedge rd_clk);
        rd_en1 = 1'b0;
        tests++;
        if ({rd_valid1, rd_data1} !== {1'b1, 16'h5A5A}) begin
            fails++;
            $display("FAIL rm1_pop got valid=%b data=%h exp valid=1 data=5a5a", rd_valid1,
                     rd_data1);
        end
        @(negedge rd_clk);
        tests++;
        if ({rd_valid1, rd_data1} !== {1'b0, 16'h5A5A}) begin
            fails++;
            $display("FAIL rm1_idle got valid=%b data=%h exp valid=0 data=5a5a", rd_valid1,
                     rd_data1);
        end
        rd_en1 = 1'b1;
        @(negedge rd_clk);
        rd_en1 = 1'b0;
        tests++;
        if ({rd_valid1, rd_data1, rd_empty1} !== {1'b1, 16'h6B6B, 1'b1}) begin
            fails++;
            $display("FAIL rm1_pop2 got valid=%b data=%h empty=%b exp valid=1 data=6b6b empty=1",
                     rd_valid1, rd_data1, rd_empty1);
        end
    endtask

    task automatic test_flush();
        logic ok;
        logic [15:0] d;
        wr_word(16'hA001);
        wr_word(16'hA002);
        wr_word(16'hA003);
        @(negedge wr_clk);
        wr_flush = 1'b1;
        wr_en    = 1'b1;
        wr_data  = 16'h9999;
        @(negedge wr_clk);
        wr_flush = 1'b0;
        wr_data  = 16'h7777;
        tests++;
        if ({wr_busy, wr_full, wr_count, wr_ovf} !== {1'b1, 1'b1, 3'd3, 1'b0}) begin
            fails++;
            $display("FAIL flush_busy got busy=%b full=%b cnt=%0d ovf=%b exp 1 1 3 0",
                     wr_busy, wr_full, wr_count, wr_ovf);
        end
        @(negedge wr_clk);
        wr_en = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge wr_clk);
            if (!wr_busy) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if ({ok, wr_full, wr_count, wr_ovf} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
            fails++;
            $display("FAIL flush_done got ok=%b full=%b cnt=%0d ovf=%b exp 1 0 0 0",
                     ok, wr_full, wr_count, wr_ovf);
        end
        @(negedge rd_clk);
        tests++;
        if ({rd_empty, rd_count, rd_unf} !== {1'b1, 3'd0, 1'b0}) begin
            fails++;
            $display("FAIL flush_rd got empty=%b cnt=%0d unf=%b exp 1 0 0", rd_empty, rd_count,
                     rd_unf);
        end
        wr_word(16'hABCD);
        wait_rd_count(3'd1, ok);
        pop_word(d);
        tests++;
        if ({ok, d} !== {1'b1, 16'hABCD}) begin
            fails++;
            $display("FAIL flush_after got ok=%b data=%h exp ok=1 data=abcd", ok, d);
        end
    endtask

    task automatic test_stream(input int half, input logic [15:0] base);
        int bad = 0;
        rd_half = half;
        fork
            begin
                int wi = 0;
                for (int k = 0; k < 3000 && wi < 20; k++) begin
                    @(negedge wr_clk);
                    if (!wr_full) begin
                        wr_en   = 1'b1;
                        wr_data = base + 16'(wi);
                        wi++;
                    end else begin
                        wr_en = 1'b0;
                    end
                end
                @(negedge wr_clk);
                wr_en = 1'b0;
            end
            begin
                int ri = 0;
                for (int k = 0; k < 3000 && ri < 20; k++) begin
                    @(negedge rd_clk);
                    if (!rd_empty) begin
                        if (rd_data !== base + 16'(ri)) begin
                            bad++;
                            $display("FAIL stream_word[%0d] got=%h exp=%h", ri, rd_data,
                                     base + 16'(ri));
                        end
                        rd_en = 1'b1;
                        ri++;
                    end else begin
                        rd_en = 1'b0;
                    end
                end
                @(negedge rd_clk);
                rd_en = 1'b0;
                tests++;
                if (ri !== 20) begin
                    fails++;
                    $display("FAIL stream_count got=%0d exp=20", ri);
                end
            end
        join
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL stream_data got %0d bad words exp 0", bad);
        end
        tests++;
        if ({rd_empty, rd_unf} !== 2'b10) begin
            fails++;
            $display("FAIL stream_end got empty=%b unf=%b exp empty=1 unf=0", rd_empty, rd_unf);
        end
    endtask

    task automatic test_reset_mid();
        logic ok;
        logic [15:0] d;
        rd_half = 6;
        wr_word(16'hB001);
        wr_word(16'hB002);
        wr_word(16'hB003);
        #5;
        rst_n = 1'b0;
        #1;
        tests++;
        if (status0() !== RST_STATUS) begin
            fails++;
            $display("FAIL midreset_status got=%b exp=%b", status0(), RST_STATUS);
        end
        tests++;
        if ({rd_valid1, rd_data1} !== 17'd0) begin
            fails++;
            $display("FAIL midreset_rdmode1 got valid=%b data=%h exp 0 0000", rd_valid1, rd_data1);
        end
        @(negedge wr_clk);
        rst_n = 1'b1;
        wr_word(16'h1234);
        wait_rd_count(3'd1, ok);
        pop_word(d);
        tests++;
        if ({ok, d, rd_empty} !== {1'b1, 16'h1234, 1'b1}) begin
            fails++;
            $display("FAIL midreset_after got ok=%b data=%h empty=%b exp 1 1234 1", ok, d,
                     rd_empty);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        wr_flush = 1'b0;
        rd_en    = 1'b0;
        wr_en1   = 1'b0;
        wr_data1 = '0;
        rd_en1   = 1'b0;
        flush1   = 1'b0;
        #25;
        rst_n = 1'b1;
        test_reset();
        test_fill();
        test_rd_mode1();
        test_flush();
        test_stream(18, 16'hC000);
        test_stream(2, 16'hD000);
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
